// File: rtl/counter_pkg.sv
// counter_pkg: definitions shared by the counter and timer blocks.
//   DIR_UP / DIR_DOWN : encodings of the Up direction input.
//   clamp()           : limits a parallel-load value to the count range.
// The clamp works on a fixed CLAMP_W-bit width so one function serves every
// counter width up to CLAMP_W-1 bits; callers extend their operands to it.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int CLAMP_W = 33;

    // Values at or above the modulus become modulus-1; others pass through.
    function automatic logic [CLAMP_W-1:0] clamp(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] modulus
    );
        logic [CLAMP_W-1:0] result;
        result = value;
        if (value >= modulus) begin
            result = modulus - CLAMP_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/rate_prescaler.sv
// rate_prescaler: divides a stream of enabled cycles down to one Tick every
// PRESCALE enabled cycles. Restart reloads the down-counter so the next Tick
// comes a full PRESCALE enabled cycles later. Asynchronous active-low Reset.
// Tick is forced low while Reset is asserted.
module rate_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic Restart,
    output logic Tick
);

    // A single-bit counter is kept even for PRESCALE=1 (it simply stays at 0).
    localparam int              PC_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PC_W-1:0] PC_RELOAD = PC_W'(PRESCALE - 1);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            step;

    // A step happens on an enabled cycle when the countdown has reached zero.
    assign step = Reset && Enable && (pc_q == '0);
    assign Tick = step;

    // Next countdown value: reload on restart or step, decrement when enabled.
    always_comb begin
        pc_d = pc_q;
        if (Restart || step) begin
            pc_d = PC_RELOAD;
        end else if (Enable) begin
            pc_d = pc_q - PC_W'(1);
        end
    end

    // Countdown register; reset leaves a full period before the first step.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q <= PC_RELOAD;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-MODULUS up/down counter with prescaler,
// parallel load (clamped to the count range) and synchronous clear.
// Synchronous priority: SyncClear > Load > step > hold.
// TerminalCount flags a step taken at the count limit and can feed the
// Enable of a following stage for cascading.
// Build option: define COUNTER_SATURATE_EN to hold at the limit instead of
// wrapping; TerminalCount still asserts on every step taken at the limit.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 2**WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Up,
    input  logic             SyncClear,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] CounterValue,
    output logic             Tick,
    output logic             TerminalCount
);

    // Modulus held in WIDTH+1 bits so MODULUS == 2**WIDTH needs no overflow care.
    localparam logic [WIDTH:0]   MOD_C = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD_C - (WIDTH+1)'(1));

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] load_val;
    logic             step;
    logic             restart;
    logic             count_up;
    logic             at_limit;

    // Clear or load both begin a fresh prescaler period.
    assign restart = SyncClear | Load;

    rate_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .Restart (restart),
        .Tick    (step)
    );

    assign count_up = (Up == DIR_UP);
    assign at_limit = count_up ? (cnt_q == MAX_C) : (cnt_q == '0);
    assign load_val = WIDTH'(clamp(CLAMP_W'(LoadValue), CLAMP_W'(MOD_C)));

    assign Tick          = step;
    assign TerminalCount = step && at_limit && !SyncClear && !Load;
    assign CounterValue  = cnt_q;

    // Next count: clear, then load, then a step in the sampled direction.
    always_comb begin
        cnt_d = cnt_q;
        if (SyncClear) begin
            cnt_d = '0;
        end else if (Load) begin
            cnt_d = load_val;
        end else if (step) begin
            if (at_limit) begin
`ifdef COUNTER_SATURATE_EN
                cnt_d = cnt_q;
`else
                cnt_d = count_up ? '0 : MAX_C;
`endif
            end else begin
                cnt_d = count_up ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
            end
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Testbench for mod_updown_counter: three instances share Clock and Reset.
//   dut_a : WIDTH=8, MODULUS=256, PRESCALE=1
//   dut_b : WIDTH=4, MODULUS=10,  PRESCALE=1
//   dut_c : WIDTH=4, MODULUS=10,  PRESCALE=4
// Expectations follow COUNTER_SATURATE_EN when it is defined for the build.
module tb_mod_updown_counter;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset;

    logic       en_a, up_a, clr_a, ld_a, tick_a, tc_a;
    logic [7:0] lv_a, cv_a;
    logic       en_b, up_b, clr_b, ld_b, tick_b, tc_b;
    logic [3:0] lv_b, cv_b;
    logic       en_c, up_c, clr_c, ld_c, tick_c, tc_c;
    logic [3:0] lv_c, cv_c;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    mod_updown_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1)) dut_a (
        .Clock(Clock), .Reset(Reset), .Enable(en_a), .Up(up_a), .SyncClear(clr_a),
        .Load(ld_a), .LoadValue(lv_a), .CounterValue(cv_a), .Tick(tick_a),
        .TerminalCount(tc_a));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_b (
        .Clock(Clock), .Reset(Reset), .Enable(en_b), .Up(up_b), .SyncClear(clr_b),
        .Load(ld_b), .LoadValue(lv_b), .CounterValue(cv_b), .Tick(tick_b),
        .TerminalCount(tc_b));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut_c (
        .Clock(Clock), .Reset(Reset), .Enable(en_c), .Up(up_c), .SyncClear(clr_c),
        .Load(ld_c), .LoadValue(lv_c), .CounterValue(cv_c), .Tick(tick_c),
        .TerminalCount(tc_c));

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        en_a = 1'b1; up_a = 1'b1;
        #2;
        checks++; if (cv_a !== 8'd0) begin failures++; $display("FAIL reset_cv_a got=%0d exp=0", cv_a); end
        checks++; if (cv_b !== 4'd0) begin failures++; $display("FAIL reset_cv_b got=%0d exp=0", cv_b); end
        checks++; if (cv_c !== 4'd0) begin failures++; $display("FAIL reset_cv_c got=%0d exp=0", cv_c); end
        checks++; if (tick_a !== 1'b0) begin failures++; $display("FAIL reset_tick_a got=%0b exp=0", tick_a); end
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL reset_tc_a got=%0b exp=0", tc_a); end
        cyc(); cyc();
        checks++; if (cv_a !== 8'd0) begin failures++; $display("FAIL reset_hold_cv_a got=%0d exp=0", cv_a); end
        en_a = 1'b0;
        Reset = 1'b1;
        cyc();
        checks++; if (cv_a !== 8'd0) begin failures++; $display("FAIL reset_release_idle got=%0d exp=0", cv_a); end
    endtask

    task automatic test_async_reset();
        ld_a = 1'b1; lv_a = 8'd37;
        cyc();
        ld_a = 1'b0;
        checks++; if (cv_a !== 8'd37) begin failures++; $display("FAIL async_load37 got=%0d exp=37", cv_a); end
        en_a = 1'b1; up_a = 1'b1;
        cyc();
        checks++; if (cv_a !== 8'd38) begin failures++; $display("FAIL async_pre_count got=%0d exp=38", cv_a); end
        Reset = 1'b0;
        #1;
        checks++; if (cv_a !== 8'd0) begin failures++; $display("FAIL async_reset_cv got=%0d exp=0", cv_a); end
        checks++; if (tick_a !== 1'b0) begin failures++; $display("FAIL async_reset_tick got=%0b exp=0", tick_a); end
        #1;
        Reset = 1'b1;
        #1;
        checks++; if (tick_a !== 1'b1) begin failures++; $display("FAIL async_release_tick got=%0b exp=1", tick_a); end
        for (int i = 1; i <= 3; i++) begin
            cyc();
            checks++; if (cv_a !== 8'(i)) begin failures++; $display("FAIL async_resume_%0d got=%0d exp=%0d", i, cv_a, i); end
        end
        en_a = 1'b0;
    endtask

    task automatic test_wrap();
        ld_b = 1'b1; lv_b = 4'd5;
        cyc();
        ld_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        #1;
        checks++; if (tick_b !== 1'b1) begin failures++; $display("FAIL wrap_mid_tick got=%0b exp=1", tick_b); end
        checks++; if (tc_b !== 1'b0) begin failures++; $display("FAIL wrap_mid_tc got=%0b exp=0", tc_b); end
        cyc();
        checks++; if (cv_b !== 4'd6) begin failures++; $display("FAIL wrap_mid_cv got=%0d exp=6", cv_b); end
        en_b = 1'b0; ld_b = 1'b1; lv_b = 4'd9;
        cyc();
        ld_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        #1;
        checks++; if (tc_b !== 1'b1) begin failures++; $display("FAIL wrap_up_tc got=%0b exp=1", tc_b); end
        cyc();
        checks++; if (cv_b !== (SAT ? 4'd9 : 4'd0)) begin failures++; $display("FAIL wrap_up_cv got=%0d exp=%0d", cv_b, SAT ? 9 : 0); end
        en_b = 1'b0; ld_b = 1'b1; lv_b = 4'd0;
        cyc();
        ld_b = 1'b0; en_b = 1'b1; up_b = 1'b0;
        #1;
        checks++; if (tc_b !== 1'b1) begin failures++; $display("FAIL wrap_down_tc got=%0b exp=1", tc_b); end
        cyc();
        checks++; if (cv_b !== (SAT ? 4'd0 : 4'd9)) begin failures++; $display("FAIL wrap_down_cv got=%0d exp=%0d", cv_b, SAT ? 0 : 9); end
        en_b = 1'b0;
    endtask

    task automatic test_load_clamp();
        logic [3:0] lvs  [4] = '{4'd12, 4'd10, 4'd15, 4'd3};
        logic [3:0] exps [4] = '{4'd9,  4'd9,  4'd9,  4'd3};
        en_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ld_b = 1'b1; lv_b = lvs[i];
            cyc();
            checks++; if (cv_b !== exps[i]) begin failures++; $display("FAIL load_clamp_%0d got=%0d exp=%0d", lvs[i], cv_b, exps[i]); end
        end
        lv_b = 4'd9;
        cyc();
        ld_b = 1'b0;
        clr_b = 1'b1; ld_b = 1'b1; lv_b = 4'd5; en_b = 1'b1; up_b = 1'b1;
        #1;
        checks++; if (tc_b !== 1'b0) begin failures++; $display("FAIL clr_load_tc got=%0b exp=0", tc_b); end
        cyc();
        checks++; if (cv_b !== 4'd0) begin failures++; $display("FAIL clr_load_cv got=%0d exp=0", cv_b); end
        clr_b = 1'b0; ld_b = 1'b0; en_b = 1'b0;
    endtask

    task automatic test_prescale();
        logic       exp_tick [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
        logic [3:0] exp_cv   [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
        logic       en_pat   [7] = '{1, 0, 0, 0, 1, 1, 1};
        logic       st_tick  [7] = '{0, 0, 0, 0, 0, 0, 1};
        logic [3:0] st_cv    [7] = '{2, 2, 2, 2, 2, 2, 3};
        clr_c = 1'b1;
        cyc();
        clr_c = 1'b0;
        checks++; if (cv_c !== 4'd0) begin failures++; $display("FAIL presc_clear got=%0d exp=0", cv_c); end
        en_c = 1'b1; up_c = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (tick_c !== exp_tick[i]) begin failures++; $display("FAIL presc_tick_%0d got=%0b exp=%0b", i, tick_c, exp_tick[i]); end
            cyc();
            checks++; if (cv_c !== exp_cv[i]) begin failures++; $display("FAIL presc_cv_%0d got=%0d exp=%0d", i, cv_c, exp_cv[i]); end
        end
        for (int i = 0; i < 7; i++) begin
            en_c = en_pat[i];
            #1;
            checks++; if (tick_c !== st_tick[i]) begin failures++; $display("FAIL stretch_tick_%0d got=%0b exp=%0b", i, tick_c, st_tick[i]); end
            cyc();
            checks++; if (cv_c !== st_cv[i]) begin failures++; $display("FAIL stretch_cv_%0d got=%0d exp=%0d", i, cv_c, st_cv[i]); end
        end
        en_c = 1'b0;
    endtask

    task automatic test_load_at_limit();
        ld_c = 1'b1; lv_c = 4'd9;
        cyc();
        ld_c = 1'b0;
        checks++; if (cv_c !== 4'd9) begin failures++; $display("FAIL lal_preload got=%0d exp=9", cv_c); end
        en_c = 1'b1; up_c = 1'b1;
        cyc(); cyc(); cyc();
        ld_c = 1'b1; lv_c = 4'd4;
        #1;
        checks++; if (tick_c !== 1'b1) begin failures++; $display("FAIL lal_tick got=%0b exp=1", tick_c); end
        checks++; if (tc_c !== 1'b0) begin failures++; $display("FAIL lal_tc got=%0b exp=0", tc_c); end
        cyc();
        ld_c = 1'b0;
        checks++; if (cv_c !== 4'd4) begin failures++; $display("FAIL lal_cv got=%0d exp=4", cv_c); end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (tick_c !== (i == 3)) begin failures++; $display("FAIL lal_restart_tick_%0d got=%0b exp=%0b", i, tick_c, i == 3); end
            cyc();
            checks++; if (cv_c !== ((i == 3) ? 4'd5 : 4'd4)) begin failures++; $display("FAIL lal_restart_cv_%0d got=%0d exp=%0d", i, cv_c, (i == 3) ? 5 : 4); end
        end
        en_c = 1'b0;
    endtask

    task automatic test_saturate();
        ld_b = 1'b1; lv_b = 4'd9;
        cyc();
        ld_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (tc_b !== (SAT ? 1'b1 : (i == 0))) begin failures++; $display("FAIL sat_tc_%0d got=%0b exp=%0b", i, tc_b, SAT ? 1'b1 : (i == 0)); end
            cyc();
            checks++; if (cv_b !== (SAT ? 4'd9 : 4'(i))) begin failures++; $display("FAIL sat_cv_%0d got=%0d exp=%0d", i, cv_b, SAT ? 9 : i); end
        end
        en_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic       dirs [4] = '{1, 0, 1, 1};
        logic [7:0] vals [4] = '{8'd11, 8'd10, 8'd11, 8'd12};
        ld_a = 1'b1; lv_a = 8'd0;
        cyc();
        ld_a = 1'b0; en_a = 1'b1; up_a = 1'b0;
        #1;
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL full_down_tc got=%0b exp=1", tc_a); end
        cyc();
        checks++; if (cv_a !== (SAT ? 8'd0 : 8'd255)) begin failures++; $display("FAIL full_down_cv got=%0d exp=%0d", cv_a, SAT ? 0 : 255); end
        en_a = 1'b0; ld_a = 1'b1; lv_a = 8'd255;
        cyc();
        ld_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
        #1;
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL full_up_tc got=%0b exp=1", tc_a); end
        cyc();
        checks++; if (cv_a !== (SAT ? 8'd255 : 8'd0)) begin failures++; $display("FAIL full_up_cv got=%0d exp=%0d", cv_a, SAT ? 255 : 0); end
        en_a = 1'b0; ld_a = 1'b1; lv_a = 8'd10;
        cyc();
        ld_a = 1'b0; en_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_a = dirs[i];
            #1;
            checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL toggle_tc_%0d got=%0b exp=0", i, tc_a); end
            cyc();
            checks++; if (cv_a !== vals[i]) begin failures++; $display("FAIL toggle_cv_%0d got=%0d exp=%0d", i, cv_a, vals[i]); end
        end
        en_a = 1'b0;
    endtask

    initial begin
        en_a = 0; up_a = 0; clr_a = 0; ld_a = 0; lv_a = '0;
        en_b = 0; up_b = 0; clr_b = 0; ld_b = 0; lv_b = '0;
        en_c = 0; up_c = 0; clr_c = 0; ld_c = 0; lv_c = '0;
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        test_reset();
        test_async_reset();
        test_wrap();
        test_load_clamp();
        test_prescale();
        test_load_at_limit();
        test_saturate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
